// File: rtl/sram_dp_sync_if.sv
// ---------------------------------------------------------------------------
// sram_dp_sync_if
//   Bundle of the two request/response ports of the dual-port synchronous
//   SRAM plus its status flags.
//
//   Per port X in {a, b}:
//     x_en     request strobe, sampled on the rising clock edge
//     x_we     1 = write, 0 = read
//     x_be     byte write enables (one bit per byte of x_wdata)
//     x_addr   word address
//     x_wdata  write data
//     x_rdata  read data; holds its last value while x_rvalid is 0
//     x_rvalid one-cycle pulse marking new data on x_rdata
//   Status:
//     init_busy  memory clear in progress; requests are ignored while high
//     collision  one-cycle pulse: same-address access with at least one write
//
//   Handshake: there is no back-pressure. A request is taken on every rising
//   edge where x_en=1 and init_busy=0; a taken read produces exactly one
//   x_rvalid pulse after a fixed latency, a taken write produces none.
//
//   Modports: master = requester side, slave = memory side.
// ---------------------------------------------------------------------------
interface sram_dp_sync_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic            a_en;
    logic            a_we;
    logic [DW/8-1:0] a_be;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_wdata;
    logic [DW-1:0]   a_rdata;
    logic            a_rvalid;

    logic            b_en;
    logic            b_we;
    logic [DW/8-1:0] b_be;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_wdata;
    logic [DW-1:0]   b_rdata;
    logic            b_rvalid;

    logic            init_busy;
    logic            collision;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata,
        input  a_rdata, a_rvalid,
        output b_en, b_we, b_be, b_addr, b_wdata,
        input  b_rdata, b_rvalid,
        input  init_busy, collision
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata,
        output a_rdata, a_rvalid,
        input  b_en, b_we, b_be, b_addr, b_wdata,
        output b_rdata, b_rvalid,
        output init_busy, collision
    );
endinterface

// File: rtl/sram_dp_sync.sv
// ---------------------------------------------------------------------------
// sram_dp_sync
//   True dual-port synchronous SRAM, DEPTH = 2**AW words of DW bits, with
//   byte write enables, an optional read output register and a hardware
//   clear sequence that zeroes every word after reset.
//
//   Ports:
//     clk          single clock, all state updates on its rising edge
//     rst_n        asynchronous active-low reset
//     bus          sram_dp_sync_if.slave: ports A/B, init_busy, collision
//     o_dbg_state  init FSM state (0 = CLEAR, 1 = READY)
//
//   Parameters:
//     DW       data width, multiple of 8
//     AW       address width
//     OUT_REG  read pipeline stages after the array: 0 or 1
// ---------------------------------------------------------------------------
module sram_dp_sync #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_dp_sync_if.slave bus,
    output logic          o_dbg_state
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    if ((DW % 8) != 0) begin : g_bad_dw
        $error("sram_dp_sync: DW must be a multiple of 8");
    end
    if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_out_reg
        $error("sram_dp_sync: OUT_REG must be 0 or 1");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_busy;

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_a_acc, w_a_wr, w_a_rd;
    logic          w_b_acc, w_b_wr, w_b_rd;

    logic [DW-1:0] r_a_rd0, r_b_rd0;
    logic          r_a_v0, r_b_v0;
    logic          r_coll;

    // ---------------------------------------------------------------------
    // Init FSM: walk the counter through every address once, then park in
    // READY. r_busy is registered so it drops on the same edge that clears
    // the last word, giving exactly DEPTH busy cycles after reset release.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == {AW{1'b1}}) begin
                r_state <= READY;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_dbg_state = (r_state == READY);

    assign w_a_acc = bus.a_en & ~r_busy;
    assign w_a_wr  = w_a_acc &  bus.a_we;
    assign w_a_rd  = w_a_acc & ~bus.a_we;
    assign w_b_acc = bus.b_en & ~r_busy;
    assign w_b_wr  = w_b_acc &  bus.b_we;
    assign w_b_rd  = w_b_acc & ~bus.b_we;

    // ---------------------------------------------------------------------
    // Array. Not reset: contents come only from the clear sequence and from
    // port writes. Port B bytes are assigned before port A bytes so that on
    // a same-address, same-byte conflict the later assignment (A) wins.
    // Clear writes and port writes never coincide because ports are gated
    // off while busy.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end
        for (int i = 0; i < NB; i++) begin
            if (w_b_wr && bus.b_be[i]) begin
                r_mem[bus.b_addr][i*8 +: 8] <= bus.b_wdata[i*8 +: 8];
            end
            if (w_a_wr && bus.a_be[i]) begin
                r_mem[bus.a_addr][i*8 +: 8] <= bus.a_wdata[i*8 +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // First read stage and collision flag. Reads sample the array before
    // this edge's writes land, so a read racing a write returns old data.
    // Data registers load only on a read so rdata holds between pulses.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rd0 <= '0;
            r_b_rd0 <= '0;
            r_a_v0  <= 1'b0;
            r_b_v0  <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_a_v0 <= w_a_rd;
            r_b_v0 <= w_b_rd;
            if (w_a_rd) begin
                r_a_rd0 <= r_mem[bus.a_addr];
            end
            if (w_b_rd) begin
                r_b_rd0 <= r_mem[bus.b_addr];
            end
            r_coll <= w_a_acc & w_b_acc & (bus.a_addr == bus.b_addr)
                      & (bus.a_we | bus.b_we);
        end
    end

    assign bus.init_busy = r_busy;
    assign bus.collision = r_coll;

    // ---------------------------------------------------------------------
    // Optional output register: one extra cycle on data and valid only;
    // collision timing is unaffected.
    // ---------------------------------------------------------------------
    if (OUT_REG == 1) begin : g_out_reg
        logic [DW-1:0] r_a_rd1, r_b_rd1;
        logic          r_a_v1, r_b_v1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_rd1 <= '0;
                r_b_rd1 <= '0;
                r_a_v1  <= 1'b0;
                r_b_v1  <= 1'b0;
            end else begin
                r_a_v1 <= r_a_v0;
                r_b_v1 <= r_b_v0;
                if (r_a_v0) begin
                    r_a_rd1 <= r_a_rd0;
                end
                if (r_b_v0) begin
                    r_b_rd1 <= r_b_rd0;
                end
            end
        end

        assign bus.a_rdata  = r_a_rd1;
        assign bus.a_rvalid = r_a_v1;
        assign bus.b_rdata  = r_b_rd1;
        assign bus.b_rvalid = r_b_v1;
    end else begin : g_out_direct
        assign bus.a_rdata  = r_a_rd0;
        assign bus.a_rvalid = r_a_v0;
        assign bus.b_rdata  = r_b_rd0;
        assign bus.b_rvalid = r_b_v0;
    end
endmodule

// File: tb/tb_sram_dp_sync.sv
// ---------------------------------------------------------------------------
// tb_sram_dp_sync
//   Drives one stimulus stream into two instances (OUT_REG=0 and OUT_REG=1)
//   and checks read data, read latency, rdata hold, collision and init_busy
//   against expectations queued when each request is issued.
// ---------------------------------------------------------------------------
module tb_sram_dp_sync;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;   // rising edges so far
    int rel = 0;   // rising edges since rst_n was last released
    always @(posedge clk) begin
        cyc++;
        if (rst_n) rel++;
    end

    // ---------------- stimulus signals ----------------
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        dbg0, dbg1;

    sram_dp_sync_if #(.DW(DW), .AW(AW)) bus0 ();
    sram_dp_sync_if #(.DW(DW), .AW(AW)) bus1 ();

    assign bus0.a_en = a_en;   assign bus1.a_en = a_en;
    assign bus0.a_we = a_we;   assign bus1.a_we = a_we;
    assign bus0.a_be = a_be;   assign bus1.a_be = a_be;
    assign bus0.a_addr = a_addr;   assign bus1.a_addr = a_addr;
    assign bus0.a_wdata = a_wdata; assign bus1.a_wdata = a_wdata;
    assign bus0.b_en = b_en;   assign bus1.b_en = b_en;
    assign bus0.b_we = b_we;   assign bus1.b_we = b_we;
    assign bus0.b_be = b_be;   assign bus1.b_be = b_be;
    assign bus0.b_addr = b_addr;   assign bus1.b_addr = b_addr;
    assign bus0.b_wdata = b_wdata; assign bus1.b_wdata = b_wdata;

    sram_dp_sync #(.DW(DW), .AW(AW), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_state(dbg0)
    );
    sram_dp_sync #(.DW(DW), .AW(AW), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(dbg1)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         q_a0[$], q_b0[$], q_a1[$], q_b1[$];
    int          coll_q[$];
    logic [31:0] last_a0 = '0, last_b0 = '0, last_a1 = '0, last_b1 = '0;
    logic [31:0] mdl [DEPTH];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // One port of one instance: valid must pulse exactly at the head entry's
    // due cycle, and rdata must equal the last expected read value every cycle.
    task automatic mon(input string nm, input logic rv, input logic [31:0] rd,
                       input int n, input rd_t head,
                       inout logic [31:0] last, output logic pop);
        logic exp_rv;
        exp_rv = (n > 0) && (head.due == cyc);
        check({nm, "_rvalid"}, {31'd0, rv}, {31'd0, exp_rv});
        pop = exp_rv;
        if (exp_rv) last = head.data;
        check({nm, "_rdata"}, rd, last);
    endtask

    always @(negedge clk) begin
        rd_t  h;
        logic p;
        logic exp_c, exp_b;
        rd_t  none;
        none = rd_t'{data: 32'd0, due: -1};

        h = (q_a0.size() > 0) ? q_a0[0] : none;
        mon("a0", bus0.a_rvalid, bus0.a_rdata, q_a0.size(), h, last_a0, p);
        if (p) void'(q_a0.pop_front());
        h = (q_b0.size() > 0) ? q_b0[0] : none;
        mon("b0", bus0.b_rvalid, bus0.b_rdata, q_b0.size(), h, last_b0, p);
        if (p) void'(q_b0.pop_front());
        h = (q_a1.size() > 0) ? q_a1[0] : none;
        mon("a1", bus1.a_rvalid, bus1.a_rdata, q_a1.size(), h, last_a1, p);
        if (p) void'(q_a1.pop_front());
        h = (q_b1.size() > 0) ? q_b1[0] : none;
        mon("b1", bus1.b_rvalid, bus1.b_rdata, q_b1.size(), h, last_b1, p);
        if (p) void'(q_b1.pop_front());

        exp_c = (coll_q.size() > 0) && (coll_q[0] == cyc);
        check("collision0", {31'd0, bus0.collision}, {31'd0, exp_c});
        check("collision1", {31'd0, bus1.collision}, {31'd0, exp_c});
        if (exp_c) void'(coll_q.pop_front());

        exp_b = !rst_n || (rel < DEPTH);
        check("init_busy0", {31'd0, bus0.init_busy}, {31'd0, exp_b});
        check("init_busy1", {31'd0, bus1.init_busy}, {31'd0, exp_b});
        check("dbg_state0", {31'd0, dbg0}, {31'd0, !exp_b});
    end

    // ---------------- driver tasks ----------------
    // Applies one cycle of requests on both ports, queues the expected read
    // data (aexp/bexp) and collision pulse, updates the byte model, and
    // waits for the sampling edge. Requests made while busy queue nothing.
    task automatic issue(input logic ae, input logic aw, input logic [3:0] abe,
                         input logic [4:0] aad, input logic [31:0] awd, input logic [31:0] aexp,
                         input logic be_, input logic bw, input logic [3:0] bbe,
                         input logic [4:0] bad, input logic [31:0] bwd, input logic [31:0] bexp,
                         input logic exp_coll);
        int   e;
        logic acc;
        a_en = ae;  a_we = aw;  a_be = abe;  a_addr = aad;  a_wdata = awd;
        b_en = be_; b_we = bw;  b_be = bbe;  b_addr = bad;  b_wdata = bwd;
        e   = cyc + 1;
        acc = rst_n && (rel >= DEPTH);
        if (acc) begin
            if (ae && !aw) begin
                q_a0.push_back(rd_t'{data: aexp, due: e});
                q_a1.push_back(rd_t'{data: aexp, due: e + 1});
            end
            if (be_ && !bw) begin
                q_b0.push_back(rd_t'{data: bexp, due: e});
                q_b1.push_back(rd_t'{data: bexp, due: e + 1});
            end
            if (exp_coll) coll_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                if (be_ && bw && bbe[i]) mdl[bad][i*8 +: 8] = bwd[i*8 +: 8];
                if (ae && aw && abe[i])  mdl[aad][i*8 +: 8] = awd[i*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wr_a(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
        issue(1'b1, 1'b1, be, ad, d, 32'd0, 1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rd_a(input logic [4:0] ad, input logic [31:0] exp);
        issue(1'b1, 1'b0, 4'hF, ad, 32'd0, exp, 1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rd_b(input logic [4:0] ad, input logic [31:0] exp);
        issue(1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 4'hF, ad, 32'd0, exp, 1'b0);
    endtask

    task automatic start_reset();
        a_en = 1'b0; b_en = 1'b0;
        rst_n = 1'b0;
        rel   = 0;
        q_a0.delete(); q_b0.delete(); q_a1.delete(); q_b1.delete(); coll_q.delete();
        last_a0 = '0; last_b0 = '0; last_a1 = '0; last_b1 = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic release_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        start_reset();
        release_after(3);

        // Read addr 7 held during the whole clear; only the first request
        // after busy drops is taken and returns the cleared value.
        for (int i = 0; i < 33; i++) begin
            issue(1'b1, 1'b0, 4'hF, 5'd7, 32'd0, 32'h0000_0000,
                  1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0);
        end
        idle();

        // Byte-enable merge.
        wr_a(5'd3, 32'hDEAD_BEEF, 4'b1111);
        wr_a(5'd3, 32'h1122_3344, 4'b0101);
        rd_b(5'd3, 32'hDE22_BE44);
        idle();

        // Write/write collision, full enables: A wins.
        issue(1'b1, 1'b1, 4'hF, 5'd9, 32'hAAAA_AAAA, 32'd0,
              1'b1, 1'b1, 4'hF, 5'd9, 32'h5555_5555, 32'd0, 1'b1);
        idle();
        // Read/read same address: both see the data, no collision.
        issue(1'b1, 1'b0, 4'hF, 5'd9, 32'd0, 32'hAAAA_AAAA,
              1'b1, 1'b0, 4'hF, 5'd9, 32'd0, 32'hAAAA_AAAA, 1'b0);

        // Write/write collision, partial enables overlapping in byte 1.
        issue(1'b1, 1'b1, 4'b0011, 5'd10, 32'h1111_1111, 32'd0,
              1'b1, 1'b1, 4'b1110, 5'd10, 32'h2222_2222, 32'd0, 1'b1);
        rd_a(5'd10, 32'h2222_1111);

        // Read/write collision: A reads old data, B's write lands.
        wr_a(5'd4, 32'h0000_0001, 4'hF);
        issue(1'b1, 1'b0, 4'hF, 5'd4, 32'd0, 32'h0000_0001,
              1'b1, 1'b1, 4'hF, 5'd4, 32'h0000_0002, 32'd0, 1'b1);
        rd_a(5'd4, 32'h0000_0002);

        // A write then B read next cycle; then a be=0 write is a no-op.
        wr_a(5'd12, 32'h0BAD_F00D, 4'hF);
        rd_b(5'd12, 32'h0BAD_F00D);
        wr_a(5'd12, 32'hFFFF_FFFF, 4'b0000);
        rd_a(5'd12, 32'h0BAD_F00D);
        idle();
        idle();

        // Fill all words from both ports at once, then read everything
        // back-to-back on both ports.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 1'b1, 4'hF, 5'(i), (32'h0101_0101 * i) ^ 32'hA5C3_0F00, 32'd0,
                  1'b1, 1'b1, 4'hF, 5'(i + 16), (32'h0101_0101 * (i + 16)) ^ 32'hA5C3_0F00, 32'd0,
                  1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 1'b0, 4'hF, 5'(i), 32'd0, mdl[i],
                  1'b1, 1'b0, 4'hF, 5'(i), 32'd0, mdl[i], 1'b0);
        end
        repeat (3) idle();

        // Reset in the middle of the clear, at counter value 10.
        start_reset();
        release_after(2);
        repeat (10) idle();
        start_reset();
        release_after(2);
        // Writes during busy must be dropped.
        issue(1'b1, 1'b1, 4'hF, 5'd31, 32'hFFFF_FFFF, 32'd0,
              1'b1, 1'b1, 4'hF, 5'd31, 32'hFFFF_FFFF, 32'd0, 1'b0);
        for (int i = 0; i < 40 && rel < DEPTH; i++) idle();
        rd_a(5'd31, 32'h0000_0000);
        rd_b(5'd31, 32'h0000_0000);
        rd_a(5'd3, 32'h0000_0000);
        repeat (4) idle();

        check("queues_drained",
              32'(q_a0.size() + q_b0.size() + q_a1.size() + q_b1.size() + coll_q.size()),
              32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_dp_sync.md
SRAM_DP_SYNC -- requirements
Module: sram_dp_sync

Interface
REQ-001 Parameter DW, default 32, data word width in bits; SHALL be a multiple of 8, and elaboration SHALL fail otherwise.
REQ-002 Parameter AW, default 5, address width; depth SHALL be DEPTH = 2**AW words.
REQ-003 Parameter OUT_REG, default 0, read output pipeline stages (0 or 1).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 a_en  input  1  port A request strobe.
REQ-007 a_we  input  1  port A write (1) or read (0).
REQ-008 a_be  input  DW/8  port A byte write enables.
REQ-009 a_addr  input  AW  port A word address.
REQ-010 a_wdata  input  DW  port A write data.
REQ-011 a_rdata  output  DW  port A read data.
REQ-012 a_rvalid  output  1  port A read-data-valid pulse.
REQ-013 b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid SHALL be port B equivalents, identical in direction, width and meaning to REQ-006..REQ-012.
REQ-014 init_busy  output  1  memory clear in progress.
REQ-015 collision  output  1  same-address conflict pulse.

Function
REQ-016 The init FSM SHALL have two states, CLEAR and READY; reset SHALL force CLEAR with the clear counter at 0.
REQ-017 In CLEAR, one word per cycle SHALL be written to all-zero at the counter address, and the counter SHALL increment.
REQ-018 After the edge that clears word DEPTH-1, the FSM SHALL move to READY; init_busy SHALL be 1 for exactly DEPTH cycles after rst_n rises.
REQ-019 While init_busy=1, port requests SHALL be ignored: no memory write, no rvalid, and no collision.
REQ-020 A request is accepted when en=1 and init_busy=0 at a rising edge.
REQ-021 An accepted write SHALL update only bytes whose be bit is 1; be=0 SHALL be a no-op write.
REQ-022 An accepted write SHALL NOT assert rvalid, and rdata SHALL hold.
REQ-023 An accepted read at edge N SHALL present memory[addr] on rdata with rvalid=1 for one cycle.
REQ-024 With OUT_REG=0, that data and pulse SHALL be registered at edge N; with OUT_REG=1, at edge N+1.
REQ-025 rdata SHALL hold its last value whenever rvalid=0.
REQ-026 Back-to-back reads, one per cycle per port, SHALL be fully pipelined with no bubbles.
REQ-027 Collision is defined as: both ports accepted, a_addr==b_addr, and at least one port writing.
REQ-028 Write/write collision: per byte, A SHALL win where both be bits are set; otherwise the byte whose be bit is set SHALL be written.
REQ-029 Read/write collision: the reading port SHALL return pre-write (old) data, and the write SHALL complete.
REQ-030 Read/read on the same address SHALL NOT be a collision; both ports SHALL return the same data.
REQ-031 collision SHALL be registered at the conflicting edge and high for exactly one cycle, independent of OUT_REG.
REQ-032 A port-A write followed next cycle by a port-B read of the same address SHALL return the new data.

Reset
REQ-033 rst_n=0 SHALL immediately force rdata 0, rvalid 0, collision 0, init_busy 1, pipeline registers 0 and the FSM to CLEAR at counter 0.
REQ-034 rst_n asserted mid-CLEAR SHALL restart the clear from address 0 after release.
REQ-035 Memory contents SHALL be defined only through the clear sequence, not by reset itself.

Verification
REQ-036 Release rst_n and hold a_en=1: init_busy SHALL be 1 for 32 cycles with a_rvalid=0 throughout; then a read of address 7 SHALL return 0x00000000.
REQ-037 A writes 0xDEADBEEF to address 3 with be=4'b1111, then A writes 0x11223344 to address 3 with be=4'b0101, then B reads address 3: b_rdata SHALL be 0xDE22BE44, delayed one extra cycle when OUT_REG=1.
REQ-038 Same edge, A writes 0xAAAAAAAA (be 4'b1111) and B writes 0x55555555 (be 4'b1111) to address 9: collision SHALL pulse once, and a subsequent read SHALL return 0xAAAAAAAA.
REQ-039 Address 4 holds 0x1, then at the same edge A reads address 4 while B writes 0x2 to it: a_rdata SHALL be 0x1 with collision=1, and the next A read SHALL return 0x2.
REQ-040 Assert rst_n=0 when the clear counter is 10, release it, then write to address 31 during busy: init_busy SHALL last 32 cycles after release, and address 31 SHALL read 0.
REQ-041 Read addresses 0..31 back-to-back on both ports at once: rvalid SHALL stay high for 32 consecutive cycles with collision=0.
